score_controller: RTL

Run-control and scheduling block for the game's score path. A single-clock FSM sequences a game through idle, clear, run and dead phases. It generates the score-advance tick from the system clock and drives the clear and freeze controls of the 6-digit BCD score counter. It also captures the high score when a run ends, and sits between the game-logic inputs (start, collision) and the score counter / 7-segment display path.

---
 rtl/dino_pkg.sv | 16 +
 rtl/score_controller_if.sv | 27 ++
 rtl/tick_prescaler.sv | 45 ++++
 rtl/score_controller.sv | 112 +++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and widths for the game's score path.
// Holds the game phase encoding and the BCD score width.
// Imported by the interface, the controller and the bench.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DEAD  = 2'd3
  } game_state_t;

  localparam int SCORE_DIGITS = 6;
  localparam int SCORE_W      = 4 * SCORE_DIGITS;

endpackage

// File: rtl/score_controller_if.sv
// Bundle between game logic / score counter (master) and the run controller (slave).
// Pure wiring, no latency.
// No backpressure: every signal is a level or a single-cycle pulse.
interface score_controller_if;
  import dino_pkg::*;

  logic                 start;
  logic                 collision;
  logic [SCORE_W-1:0]   score_in;
  logic                 tick;
  logic                 score_clear;
  logic                 frozen;
  game_state_t          game_state;
  logic [SCORE_W-1:0]   high_score;
  logic                 new_record;

  modport master (
    output start, collision, score_in,
    input  tick, score_clear, frozen, game_state, high_score, new_record
  );

  modport slave (
    input  start, collision, score_in,
    output tick, score_clear, frozen, game_state, high_score, new_record
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the score-advance tick.
// Tick is registered: it appears the cycle after the counter sits at TICK_DIV-1.
// No backpressure; en low holds the count, clr forces it back to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick pulse; clear wins over enable.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      tick_d = (cnt_q == CNT_MAX);
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/score_controller.sv
// Run-control FSM for the score path: idle/clear/run/dead, tick generation, high-score capture.
// All outputs registered; high_score/new_record settle two cycles after a collision.
// Optional HIGH_SCORE_EN macro builds the high-score register; without it DEAD takes start at once.
module score_controller
  import dino_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic               clk,
  input  logic               reset,
  score_controller_if.slave  bus
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  game_state_t state_q, state_d;
  logic        score_clear_q, score_clear_d;
  logic        frozen_q, frozen_d;
  logic        cmp_busy;
  logic        pre_clr, pre_en, pre_tick;

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               new_record_q, new_record_d;
  logic               cmp_pending_q, cmp_pending_d;

  assign cmp_busy = cmp_pending_q;
`else
  logic unused_score;

  assign cmp_busy     = 1'b0;
  assign unused_score = ^bus.score_in;
`endif

  // Phase sequencing plus the registered control outputs derived from the next phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN:   if (bus.collision) state_d = DEAD;
      DEAD:  if (bus.start && !cmp_busy) state_d = CLEAR;
    endcase
    score_clear_d = (state_d == CLEAR);
    frozen_d      = (state_d != RUN);

`ifdef HIGH_SCORE_EN
    high_score_d  = high_score_q;
    new_record_d  = new_record_q;
    cmp_pending_d = cmp_pending_q;
    if (state_q == CLEAR) new_record_d = 1'b0;
    if (state_q == RUN && bus.collision) cmp_pending_d = 1'b1;
    // Packed BCD orders like binary, so a plain unsigned compare is exact.
    if (state_q == DEAD && cmp_pending_q) begin
      if (bus.score_in > high_score_q) begin
        high_score_d = bus.score_in;
        new_record_d = 1'b1;
      end
      cmp_pending_d = 1'b0;
    end
`endif
  end

  // Single state/output register bank for the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      score_clear_q <= 1'b0;
      frozen_q      <= 1'b1;
`ifdef HIGH_SCORE_EN
      high_score_q  <= '0;
      new_record_q  <= 1'b0;
      cmp_pending_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      score_clear_q <= score_clear_d;
      frozen_q      <= frozen_d;
`ifdef HIGH_SCORE_EN
      high_score_q  <= high_score_d;
      new_record_q  <= new_record_d;
      cmp_pending_q <= cmp_pending_d;
`endif
    end
  end

  // Collision holds the prescaler so it beats a coincident tick.
  assign pre_clr = (state_q == CLEAR);
  assign pre_en  = (state_q == RUN) && !bus.collision;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (pre_tick)
  );

  assign bus.tick        = pre_tick;
  assign bus.score_clear = score_clear_q;
  assign bus.frozen      = frozen_q;
  assign bus.game_state  = state_q;
`ifdef HIGH_SCORE_EN
  assign bus.high_score  = high_score_q;
  assign bus.new_record  = new_record_q;
`else
  assign bus.high_score  = '0;
  assign bus.new_record  = 1'b0;
`endif

endmodule
